// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the 7-segment display
//               scheduler. Holds the FSM state encoding, digit and source
//               codes, and the double-dabble nibble adjust helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [3:0] DIG_BLANK   = 4'd15;
    localparam logic [3:0] SRC_RX_CODE = 4'd1;
    localparam logic [3:0] SRC_TX_CODE = 4'd2;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_RX   = 2'b01;
    localparam logic [1:0] SEL_TX   = 2'b10;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the next shift, so bias it by 3 first.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 8-bit binary to 3-digit BCD converter using
//               double-dabble, one iteration per clock, 8 iterations.
// Ports       : clk   - clock, posedge
//               rst_n - asynchronous active-low reset
//               start - load bin and begin (ignored while a conversion runs)
//               bin   - binary byte to convert
//               done  - high for one cycle once all 8 iterations are done;
//                       bcd is valid during that cycle
//               bcd   - {hundreds, tens, ones}
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic        running_q, running_d;
    logic [3:0]  iter_q,    iter_d;
    logic [19:0] shift_q,   shift_d;   // {hundreds, tens, ones, binary}
    logic [11:0] adj;

    always_comb begin
        running_d = running_q;
        iter_d    = iter_q;
        shift_d   = shift_q;
        adj       = {dabble_adj(shift_q[19:16]),
                     dabble_adj(shift_q[15:12]),
                     dabble_adj(shift_q[11:8])};

        if (!running_q) begin
            if (start) begin
                running_d = 1'b1;
                iter_d    = 4'd0;
                shift_d   = {12'd0, bin};
            end
        end else if (iter_q == 4'd8) begin
            // Result is presented via done for exactly this one cycle.
            running_d = 1'b0;
        end else begin
            shift_d = {adj[10:0], shift_q[7:0], 1'b0};
            iter_d  = iter_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            iter_q    <= 4'd0;
            shift_q   <= 20'd0;
        end else begin
            running_q <= running_d;
            iter_q    <= iter_d;
            shift_q   <= shift_d;
        end
    end

    assign done = running_q && (iter_q == 4'd8);
    assign bcd  = shift_q[19:8];

endmodule
`default_nettype wire

// File: rtl/seg_disp_sched.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_sched
// Description : Shares a 4-digit 7-segment scanner between UART RX and TX
//               byte sources. Latches the newest byte per source, arbitrates
//               round-robin, holds each source for a dwell time, converts the
//               byte to BCD and drives the scanner digits and scan tick.
// Ports       : CLK, RST_n          - clock / async active-low reset
//               rx_valid, rx_data  - RX byte strobe and data
//               tx_valid, tx_data  - TX byte strobe and data
//               q3                 - source digit (1=RX, 2=TX, 15=blank)
//               q2, q1, q0         - BCD hundreds, tens, ones
//               scan_tick          - one-cycle pulse every SCAN_DIV cycles
//               src_sel            - 00 none, 01 RX shown, 10 TX shown
//               busy               - high while converting or showing
// Revision    : 1.0 - initial release
// ============================================================================
module seg_disp_sched
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 12500,
    parameter int DWELL_TICKS = 2000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic [3:0] q3,
    output logic [3:0] q2,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic       scan_tick,
    output logic [1:0] src_sel,
    output logic       busy
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int DWELL_W = $clog2(DWELL_TICKS + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(DWELL_TICKS);

    state_t             state_q,     state_d;
    logic               rx_pend_q,   rx_pend_d;
    logic               tx_pend_q,   tx_pend_d;
    logic [7:0]         rx_byte_q,   rx_byte_d;
    logic [7:0]         tx_byte_q,   tx_byte_d;
    logic               last_rx_q,   last_rx_d;   // 1: RX was served last
    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic [3:0]         q3_q, q3_d, q2_q, q2_d, q1_q, q1_d, q0_q, q0_d;
    logic [1:0]         src_sel_q,   src_sel_d;

    logic               pick_rx;
    logic               conv_start;
    logic [7:0]         conv_byte;
    logic               conv_done;
    logic [11:0]        conv_bcd;

    bin2bcd_seq u_bin2bcd (
        .clk   (CLK),
        .rst_n (RST_n),
        .start (conv_start),
        .bin   (conv_byte),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign scan_tick = (scan_cnt_q == SCAN_LAST);

    always_comb begin
        state_d    = state_q;
        rx_pend_d  = rx_pend_q;
        tx_pend_d  = tx_pend_q;
        rx_byte_d  = rx_byte_q;
        tx_byte_d  = tx_byte_q;
        last_rx_d  = last_rx_q;
        dwell_d    = dwell_q;
        q3_d       = q3_q;
        q2_d       = q2_q;
        q1_d       = q1_q;
        q0_d       = q0_q;
        src_sel_d  = src_sel_q;
        pick_rx    = 1'b0;
        conv_start = 1'b0;
        conv_byte  = rx_byte_q;
        scan_cnt_d = scan_tick ? '0 : (scan_cnt_q + 1'b1);

        case (state_q)
            IDLE: begin
                if (rx_pend_q || tx_pend_q) begin
                    // On a tie, the source not served last wins.
                    pick_rx    = rx_pend_q && (!tx_pend_q || !last_rx_q);
                    conv_start = 1'b1;
                    conv_byte  = pick_rx ? rx_byte_q : tx_byte_q;
                    last_rx_d  = pick_rx;
                    if (pick_rx) begin
                        rx_pend_d = 1'b0;
                    end else begin
                        tx_pend_d = 1'b0;
                    end
                    state_d = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    // All four digits commit together on this edge.
                    q3_d      = last_rx_q ? SRC_RX_CODE : SRC_TX_CODE;
                    q2_d      = conv_bcd[11:8];
                    q1_d      = conv_bcd[7:4];
                    q0_d      = conv_bcd[3:0];
                    src_sel_d = last_rx_q ? SEL_RX : SEL_TX;
                    dwell_d   = DWELL_INIT;
                    state_d   = SHOW;
                end
            end
            SHOW: begin
                if (scan_tick) begin
                    dwell_d = dwell_q - 1'b1;
                    if (dwell_q == DWELL_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture comes last so a strobe coinciding with consumption of the
        // same source keeps the fresh byte pending.
        if (rx_valid) begin
            rx_pend_d = 1'b1;
            rx_byte_d = rx_data;
        end
        if (tx_valid) begin
            tx_pend_d = 1'b1;
            tx_byte_d = tx_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            rx_pend_q  <= 1'b0;
            tx_pend_q  <= 1'b0;
            rx_byte_q  <= 8'd0;
            tx_byte_q  <= 8'd0;
            last_rx_q  <= 1'b0;
            scan_cnt_q <= '0;
            dwell_q    <= '0;
            q3_q       <= DIG_BLANK;
            q2_q       <= DIG_BLANK;
            q1_q       <= DIG_BLANK;
            q0_q       <= DIG_BLANK;
            src_sel_q  <= SEL_NONE;
        end else begin
            state_q    <= state_d;
            rx_pend_q  <= rx_pend_d;
            tx_pend_q  <= tx_pend_d;
            rx_byte_q  <= rx_byte_d;
            tx_byte_q  <= tx_byte_d;
            last_rx_q  <= last_rx_d;
            scan_cnt_q <= scan_cnt_d;
            dwell_q    <= dwell_d;
            q3_q       <= q3_d;
            q2_q       <= q2_d;
            q1_q       <= q1_d;
            q0_q       <= q0_d;
            src_sel_q  <= src_sel_d;
        end
    end

    assign q3      = q3_q;
    assign q2      = q2_q;
    assign q1      = q1_q;
    assign q0      = q0_q;
    assign src_sel = src_sel_q;
    assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
Scheduler that shares the 4-digit 7-segment scanner between two byte sources: UART RX data and UART TX data.
- Latches the newest byte from each source.
- Arbitrates round-robin and holds each source on the display for a minimum dwell time.
- Converts the byte to three BCD digits with a sequential double-dabble.
- Drives the scanner's four digit nibbles and generates its scan-advance tick.

Parameters:
SCAN_DIV, 12500, CLK cycles per scan_tick pulse (>=2).
DWELL_TICKS, 2000, scan_tick pulses a source stays on display before re-arbitration (>=1).

Ports:
CLK  in  1  system clock, all logic on posedge.
RST_n  in  1  asynchronous active-low reset.
rx_valid  in  1  one-cycle strobe: rx_data is a new byte.
rx_data  in  8  RX byte.
tx_valid  in  1  one-cycle strobe: tx_data is a new byte.
tx_data  in  8  TX byte.
q3  out  4  source digit: 1=RX, 2=TX, 15=blank.
q2  out  4  BCD hundreds.
q1  out  4  BCD tens.
q0  out  4  BCD ones.
scan_tick  out  1  one-CLK pulse every SCAN_DIV cycles; this is the scanner's advance input.
src_sel  out  2  00 none, 01 RX shown, 10 TX shown.
busy  out  1  high in CONV or SHOW.

Behaviour:
- Reset (async, RST_n=0):
  - q3..q0 = 15 (blank); src_sel = 00; busy = 0; scan_tick = 0.
  - state = IDLE; both pending flags cleared; scan and dwell counters cleared.
  - last_served = TX, so RX wins the first tie.
- Capture:
  - A valid strobe sets that source's pend flag and overwrites its byte register. Latest byte wins and no queueing is done.
  - If a valid strobe coincides with the arbiter consuming the same source, the new byte is kept and pend stays 1.
- Scan divider:
  - Free-running counter 0..SCAN_DIV-1.
  - scan_tick = 1 during the cycle the counter equals SCAN_DIV-1.
  - First pulse occurs SCAN_DIV cycles after reset release.
- FSM states and transitions:
  - IDLE:
    - If exactly one pend is set, select that source.
    - If both are set, select the source != last_served.
    - Load the byte into the converter, clear the selected pend, set last_served, go to CONV.
    - If none is set, stay in IDLE; q outputs keep their last value.
  - CONV:
    - 8 iterations, one per CLK.
    - Each iteration: for each of the 3 BCD nibbles, add 3 if the nibble >= 5; then shift the 20-bit {bcd[11:0], bin[7:0]} left by 1.
    - On the edge after the 8th iteration, load q2..q0 from BCD and q3 from the source code, update src_sel, and go to SHOW.
    - All four nibbles change on the same edge; no partial digit update is ever visible.
    - dwell counter = DWELL_TICKS on entry to SHOW.
  - SHOW:
    - Decrement dwell on each scan_tick.
    - When the decrement takes it to 0, go to IDLE.
    - Pend flags keep capturing during SHOW.
- Latency: rx_valid/tx_valid sampled at edge 0 with FSM in IDLE and no competitor -> new q visible after edge 10. Breakdown: edge 1 IDLE select, edges 2-9 iterations, edge 10 load.
- Width rules: bytes 0..255 give hundreds 0..2, so q2 <= 2 always.
- Reset mid-CONV/SHOW: everything returns to reset values immediately. The byte in flight is discarded and never displayed.
- A strobe during reset is ignored.

Decomposition:
- Package seg_pkg holds:
  - state enum IDLE/CONV/SHOW;
  - DIG_BLANK = 4'd15;
  - SRC_RX_CODE = 4'd1, SRC_TX_CODE = 4'd2;
  - SEL_NONE/SEL_RX/SEL_TX 2-bit codes.
- One sub-module, bin2bcd_seq:
  - inputs start and bin[7:0]; outputs done and bcd[11:0];
  - 8-cycle double-dabble, start accepted only when idle.
- Arbitration, dwell and scan divider stay in the top module.

Test Plan:
(Sim parameters: SCAN_DIV=4, DWELL_TICKS=3.)
1. Assert RST_n=0 then release -> q3..q0=15,15,15,15, src_sel=00, busy=0; first scan_tick 4 cycles after release, then every 4 cycles.
2. rx_valid with rx_data=0xFF -> exactly 10 edges later q3..q0=1,2,5,5, src_sel=01, busy=1; busy drops after 3 scan_ticks; q stays 1,2,5,5.
3. tx_valid with tx_data=0x07 -> q3..q0=2,0,0,7, src_sel=10.
4. rx_valid rx_data=0x2A and tx_valid tx_data=0x64 on the same cycle from reset -> q=1,0,4,2 first; after 3 scan_ticks plus 10 cycles, q=2,1,0,0.
5. During SHOW, rx 0x10 then rx 0x11 -> only one further conversion, q=1,0,1,7; the value 16 is never displayed.
6. Pull RST_n low during CONV of 0x99 -> q blank within the same cycle (async), src_sel=00; after release q stays blank with no conversion.
